// File: rtl/mmio_periph_pkg.sv
// Register map and field layout shared by the IO hub and its FIFO.
// Latency: n/a (constants, types and a byte-merge helper only).
// Backpressure: n/a.
package mmio_periph_pkg;

  // Bit index of each register within the one-hot word address.
  localparam int REG_GPIO_OUT  = 0;
  localparam int REG_UART_DATA = 1;
  localparam int REG_UART_CTRL = 2;
  localparam int REG_GPIO_IN   = 3;
  localparam int REG_TIMER     = 4;
  localparam int REG_TIMER_CMP = 5;
  localparam int REG_IRQ_CTRL  = 6;
  localparam int NUM_SEL_BITS  = 7;

  // Write-1-to-clear and R/W field positions.
  localparam int CTRL_OVF_BIT  = 10;
  localparam int IRQ_FLAG_BIT  = 0;
  localparam int IRQ_EN_BIT    = 1;

  // UART_CTRL read layout; bit 9 (full) sits where existing firmware polls.
  typedef struct packed {
    logic [6:0] rsvd_hi;   // [31:25]
    logic [8:0] count;     // [24:16]
    logic [4:0] rsvd_mid;  // [15:11]
    logic       ovf;       // [10]
    logic       full;      // [9]
    logic       empty;     // [8]
    logic [7:0] rsvd_lo;   // [7:0]
  } uart_ctrl_t;

  // Replace the bytes of old_val selected by wmask with those of new_val.
  function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wmask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = wmask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// First-word-fall-through FIFO feeding the UART emitter.
// Latency: a pushed entry is visible at dat_o/vld_o the cycle after the push.
// Backpressure: pushes while full are refused (full_o); pops only when vld_o.
// Ports: push_i/push_dat_i/full_o write side, pop_i/vld_o/dat_o read side,
//        count_o current fill (log2(DEPTH)+1 bits).
module io_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     vld_o,
  output logic [W-1:0]             dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign vld_o   = (count_q != '0);
  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Full is judged on the current count, so a pop in the same cycle does
  // not make room for a push.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & vld_o;

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/mmio_periph.sv
// CPU IO-window hub: GPIO out/in, UART TX FIFO with sticky overflow, timer+IRQ.
// Latency: writes take effect on the write edge; rdata valid the cycle after rstrb.
// Backpressure: UART_DATA writes while the FIFO is full are dropped and flagged.
// Ports: sel/word_addr/wdata/wmask/rstrb/rdata CPU side, gpio_out/gpio_in pins,
//        tx_data/tx_valid/tx_ready to emitter_uart, irq timer interrupt.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int GPIO_OUT_W     = 8,
  parameter int GPIO_IN_W      = 8,
  parameter bit OUT_ACTIVE_LOW = 1'b1,
  parameter int TX_FIFO_DEPTH  = 16,
  parameter int TIMER_W        = 32,
  parameter int ADDR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sel,
  input  logic [ADDR_W-1:0]     word_addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  input  logic                  rstrb,
  output logic [31:0]           rdata,
  output logic [GPIO_OUT_W-1:0] gpio_out,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  irq
);

  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic [NUM_SEL_BITS-1:0] hit, wr_hit;
  logic                    wr_en, rd_en;
  logic                    unused_addr;

  // Select bits beyond the register map (or absent for narrow ADDR_W) decode to nothing.
  for (genvar gi = 0; gi < NUM_SEL_BITS; gi++) begin : g_hit
    if (gi < ADDR_W) begin : g_on
      assign hit[gi] = word_addr[gi];
    end else begin : g_off
      assign hit[gi] = 1'b0;
    end
  end
  assign unused_addr = ^word_addr;

  assign wr_en  = sel & (|wmask);
  assign rd_en  = sel & rstrb;
  assign wr_hit = {NUM_SEL_BITS{wr_en}} & hit;

  logic [GPIO_OUT_W-1:0] gpio_q, gpio_d;
  logic [GPIO_IN_W-1:0]  sync1_q, sync2_q;
  logic [TIMER_W-1:0]    timer_q, timer_d, cmp_q, cmp_d;
  logic                  flag_q, flag_d, en_q, en_d, irq_q;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_cnt;
  uart_ctrl_t            uart_st;

  io_tx_fifo #(
    .W     (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (wr_hit[REG_UART_DATA]),
    .push_dat_i (wdata[7:0]),
    .full_o     (fifo_full),
    .pop_i      (tx_ready),
    .vld_o      (tx_valid),
    .dat_o      (tx_data),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    gpio_d  = wr_hit[REG_GPIO_OUT] ? wdata[GPIO_OUT_W-1:0] : gpio_q;
    // A load replaces the increment for that cycle.
    timer_d = wr_hit[REG_TIMER]
              ? TIMER_W'(apply_wmask(32'(timer_q), wdata, wmask))
              : timer_q + TIMER_W'(1);
    cmp_d   = wr_hit[REG_TIMER_CMP]
              ? TIMER_W'(apply_wmask(32'(cmp_q), wdata, wmask))
              : cmp_q;
    // Comparing the current counter also catches a freshly loaded value.
    // Set has priority over write-1-clear.
    flag_d  = (timer_q == cmp_q) |
              (flag_q & ~(wr_hit[REG_IRQ_CTRL] & wdata[IRQ_FLAG_BIT]));
    en_d    = wr_hit[REG_IRQ_CTRL] ? wdata[IRQ_EN_BIT] : en_q;
    // Dropped byte sets overflow even when a pop happens on the same edge.
    ovf_d   = (wr_hit[REG_UART_DATA] & fifo_full) |
              (ovf_q & ~(wr_hit[REG_UART_CTRL] & wdata[CTRL_OVF_BIT]));
  end

  always_comb begin
    uart_st       = '0;
    uart_st.count = 9'(fifo_cnt);
    uart_st.ovf   = ovf_q;
    uart_st.full  = fifo_full;
    uart_st.empty = ~tx_valid;
  end

  // Lowest selected index wins on a multi-hot read; rdata holds between strobes.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if      (hit[REG_GPIO_OUT])  rdata_d = 32'(gpio_q);
      else if (hit[REG_UART_DATA]) rdata_d = '0;
      else if (hit[REG_UART_CTRL]) rdata_d = uart_st;
      else if (hit[REG_GPIO_IN])   rdata_d = 32'(sync2_q);
      else if (hit[REG_TIMER])     rdata_d = 32'(timer_q);
      else if (hit[REG_TIMER_CMP]) rdata_d = 32'(cmp_q);
      else if (hit[REG_IRQ_CTRL])  rdata_d = {30'b0, en_q, flag_q};
      else                         rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      timer_q <= '0;
      cmp_q   <= '0;
      flag_q  <= 1'b0;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      en_q    <= en_d;
      irq_q   <= flag_q & en_q;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpio_out = OUT_ACTIVE_LOW ? ~gpio_q : gpio_q;
  assign rdata    = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_periph.sv
// Bench for mmio_periph: directed scenarios then randomized bus traffic,
// all checked against a transaction-level model (byte queue, timer as
// base + elapsed edges, flags as booleans).
module tb_mmio_periph;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  word_addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rstrb = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  mmio_periph #(
    .GPIO_OUT_W     (8),
    .GPIO_IN_W      (8),
    .OUT_ACTIVE_LOW (1'b1),
    .TX_FIFO_DEPTH  (16),
    .TIMER_W        (32),
    .ADDR_W         (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sel       (sel),
    .word_addr (word_addr),
    .wdata     (wdata),
    .wmask     (wmask),
    .rstrb     (rstrb),
    .rdata     (rdata),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  logic [7:0]  q[$];
  logic [7:0]  gpio_m;
  logic        ovf_m, flag_m, en_m, irq_m;
  logic [31:0] cmp_m, tm_base, rdata_m;
  int          tm_ref;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Counter value seen by the edge numbered e.
  function automatic logic [31:0] tval(input int e);
    return tm_base + 32'(e - tm_ref);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a, input logic [31:0] tv);
    logic [31:0] st;
    st = (32'(q.size()) << 16) | (32'(ovf_m) << 10) |
         ((q.size() == 16) ? 32'h200 : 32'h0) | ((q.size() == 0) ? 32'h100 : 32'h0);
    if (a[0]) return {24'h0, gpio_m};
    if (a[1]) return 32'h0;
    if (a[2]) return st;
    if (a[3]) return {24'h0, gpio_in};
    if (a[4]) return tv;
    if (a[5]) return cmp_m;
    if (a[6]) return {30'h0, en_m, flag_m};
    return 32'h0;
  endfunction

  // Called while reset is being released (between edges).
  task automatic model_reset();
    q.delete();
    gpio_m = '0; ovf_m = 0; flag_m = 0; en_m = 0; irq_m = 0;
    cmp_m = '0; rdata_m = '0; tm_base = '0;
    tm_ref = edge_n + 1;
  endtask

  // One bus cycle: drive, predict the effect of the coming edge, check after it.
  task automatic step(input logic s, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic r);
    int          e = edge_n + 1;
    logic [31:0] tv = tval(e);
    logic        wr = s && (m != 0);
    logic        pop_ok = tx_ready && (q.size() > 0);
    logic        full = (q.size() == 16);
    logic        irq_n = flag_m & en_m;
    logic        flag_n = (tv == cmp_m) | (flag_m & !(wr && a[6] && d[0]));
    logic [7:0]  gexp;
    sel = s; word_addr = a; wdata = d; wmask = m; rstrb = r;
    if (s && r) rdata_m = exp_rd(a, tv);
    if (wr && a[6]) en_m = d[1];
    if (wr && a[0]) gpio_m = d[7:0];
    if (wr && a[5]) cmp_m = merge(cmp_m, d, m);
    if (wr && a[4]) begin tm_base = merge(tv, d, m); tm_ref = e + 1; end
    if (pop_ok) void'(q.pop_front());
    if (wr && a[1] && !full) q.push_back(d[7:0]);
    if (wr && a[1] && full) ovf_m = 1;
    else if (wr && a[2] && d[10]) ovf_m = 0;
    flag_m = flag_n;
    irq_m  = irq_n;
    @(posedge clk); #1;
    gexp = ~gpio_m;
    chk("rdata", rdata, rdata_m);
    chk("gpio_out", 32'(gpio_out), 32'(gexp));
    chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
    chk("irq", 32'(irq), 32'(irq_m));
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b[4];
    logic [31:0] ev;
    int          nl, k;
    logic [7:0]  a;
    int          op;

    // 1. reset values
    repeat (3) @(negedge clk);
    chk("rst_gpio_out", 32'(gpio_out), 32'hFF);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); rstn = 1'b1; model_reset();
    step(1, 8'h10, 0, 0, 1); chk("t1_timer", rdata, 32'h0);
    step(1, 8'h01, 0, 0, 1); chk("t1_gpio", rdata, 32'h0);
    step(1, 8'h04, 0, 0, 1); chk("t1_uctrl", rdata, 32'h100);

    // 2. GPIO out write/readback
    step(1, 8'h01, 32'hA5, 4'hF, 0); chk("t2_gpio_out", 32'(gpio_out), 32'h5A);
    step(1, 8'h01, 0, 0, 1);          chk("t2_gpio_rd", rdata, 32'hA5);

    // 3. fill past full, drain, clear overflow
    tx_ready = 0;
    for (int i = 0; i < 17; i++) step(1, 8'h02, 32'(i), 4'h1, 0);
    step(1, 8'h04, 0, 0, 1); chk("t3_uctrl_full", rdata, 32'h0010_0600);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", 32'(tx_data), 32'(i));
      idle();
    end
    chk("t3_empty", 32'(tx_valid), 32'h0);
    step(1, 8'h04, 32'h400, 4'hF, 0);
    step(1, 8'h04, 0, 0, 1); chk("t3_ovf_clr", rdata, 32'h100);

    // 4. simultaneous push/pop at count 3
    tx_ready = 0;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) step(1, 8'h02, 32'(b[i]), 4'hF, 0);
    tx_ready = 1;
    step(1, 8'h02, 32'(b[3]), 4'hF, 0);
    tx_ready = 0;
    step(1, 8'h04, 0, 0, 1); chk("t4_count", rdata, 32'h0003_0000);
    tx_ready = 1;
    for (int i = 1; i < 4; i++) begin
      chk("t4_order", 32'(tx_data), 32'(b[i]));
      idle();
    end
    chk("t4_empty", 32'(tx_valid), 32'h0);
    tx_ready = 0;

    // 5. timer compare, irq, wrap
    step(1, 8'h10, 32'd0, 4'hF, 0);
    step(1, 8'h20, 32'd100, 4'hF, 0);
    step(1, 8'h40, 32'h3, 4'hF, 0);
    step(1, 8'h10, 32'd90, 4'hF, 0);
    nl = edge_n;
    k = 0;
    while (!irq && k < 40) begin idle(); k++; end
    chk("t5_irq_rise_edges", 32'(edge_n - nl), 32'd12);
    step(1, 8'h40, 0, 0, 1); chk("t5_irq_ctrl", rdata, 32'h3);
    step(1, 8'h40, 32'h3, 4'hF, 0);
    idle(); chk("t5_irq_drop", 32'(irq), 32'h0);
    step(1, 8'h10, 32'hFFFF_FFFD, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      ev = 32'hFFFF_FFFD + 32'(i);
      step(1, 8'h10, 0, 0, 1); chk("t5_wrap", rdata, ev);
    end

    // 6. input synchroniser, then reset in the middle of a drain
    gpio_in = 8'h3C;
    idle(); idle();
    step(1, 8'h08, 0, 0, 1); chk("t6_gpio_in", rdata, 32'h3C);
    tx_ready = 0;
    for (int i = 0; i < 5; i++) step(1, 8'h02, $urandom, 4'h1, 0);
    tx_ready = 1;
    idle(); idle();
    #2 rstn = 1'b0;
    #1;
    chk("rst2_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst2_gpio_out", 32'(gpio_out), 32'hFF);
    chk("rst2_rdata", rdata, 32'h0);
    @(negedge clk); rstn = 1'b1; model_reset();
    idle(); idle(); idle();
    step(1, 8'h04, 0, 0, 1); chk("rst2_uctrl", rdata, 32'h100);

    // Randomized traffic: multi-hot decode, partial masks, FIFO pressure.
    for (int it = 0; it < 600; it++) begin
      tx_ready = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = 8'(1 << $urandom_range(0, 7));
      if (op < 5)      step(1, a, $urandom, 4'($urandom), 0);
      else if (op < 8) step(1, a, 0, 0, 1);
      else if (op < 9) step(0, a, $urandom, 4'hF, 1'($urandom_range(0, 1)));
      else             idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
